mult_div_sequencer: RTL

- Iterative multicycle sequencer for MIPS MULT/MULTU/DIV/DIVU. Owns the architectural HI/LO registers.
- Sits beside the EX-stage ALU. Its stall output holds the pipeline while HI/LO hazards or structural conflicts exist.
- Radix-2 shift-add multiply and restoring divide. Magnitude datapath with sign fix-up, one bit per cycle.

---
 rtl/mult_div_sequencer_pkg.sv | 26 ++
 rtl/mult_div_sequencer_iter.sv | 36 +++
 rtl/mult_div_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mult_div_sequencer_pkg.sv
// Shared constants for the MULT/DIV sequencer and the instruction decoder:
// operation encodings, FSM state encodings and small op-decode helpers.
package mult_div_sequencer_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FIXUP = 2'b10
    } state_t;

    // Divide ops have the upper encoding bit set.
    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

    // Signed ops (MULT, DIV) have the lower encoding bit clear.
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mult_div_sequencer_iter.sv
// md_iter_step: one radix-2 iteration on magnitudes.
// Multiply: acc = {upper, multiplier}; add operand to upper when acc[0] is set,
// then shift the whole register right by one (carry enters at the top).
// Divide: acc = {remainder, quotient}; shift left, trial-subtract the divisor
// from the remainder, keep it and set quotient bit 0 when non-negative.
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // Single combinational add/shift or subtract/shift step.
    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        // Remainder after the left shift needs one extra bit.
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        trial  = rem_sh - {1'b0, operand};
        if (is_div) begin
            if (!trial[WIDTH]) begin
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Works on operand magnitudes one bit per cycle and applies the sign fix-up
// in a final cycle. Holds the pipeline while HI/LO are not yet valid.
module mult_div_sequencer
    import mult_div_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inStart,
    input  logic [1:0]       inOp,
    input  logic [WIDTH-1:0] inRs,
    input  logic [WIDTH-1:0] inRt,
    input  logic             inReadHiLo,
    input  logic             inWriteHi,
    input  logic             inWriteLo,
    input  logic             inFlush,
    output logic [WIDTH-1:0] outHi,
    output logic [WIDTH-1:0] outLo,
    output logic             outBusy,
    output logic             outDone,
    output logic             outStall
);

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_q;
    logic               neg_res_q, neg_rem_q, div_zero_q;
    logic [WIDTH-1:0]   operand_q, orig_rs_q, hi_q, lo_q;
    logic [2*WIDTH-1:0] acc_q, acc_next;
    logic               done_q;

    logic               accept, mt_ok, finish, last_iter, signed_op;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

    assign accept    = (state == ST_IDLE) & inStart & ~inFlush;
    assign mt_ok     = (state == ST_IDLE) & ~inStart & ~inFlush;
    assign finish    = (state == ST_FIXUP) & ~inFlush;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign signed_op = is_signed_op(inOp);
    assign rs_mag    = (signed_op & inRs[WIDTH-1]) ? -inRs : inRs;
    assign rt_mag    = (signed_op & inRt[WIDTH-1]) ? -inRt : inRt;

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_op(op_q)),
        .acc      (acc_q),
        .operand  (operand_q),
        .acc_next (acc_next)
    );

    // Sign fix-up of the magnitude result; divide-by-zero overrides both halves.
    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (div_zero_q) begin
            fix_hi = orig_rs_q;
            fix_lo = '1;
        end else if (is_div_op(op_q)) begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // FSM next state: flush returns any in-flight operation to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept) next_state = ST_RUN;
            ST_RUN: begin
                if (inFlush)        next_state = ST_IDLE;
                else if (last_iter) next_state = ST_FIXUP;
            end
            ST_FIXUP: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Operand capture, iteration register, counter, HI/LO and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            op_q       <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            operand_q  <= '0;
            orig_rs_q  <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= finish;
            if (accept) begin
                cnt        <= '0;
                op_q       <= inOp;
                neg_res_q  <= signed_op & (inRs[WIDTH-1] ^ inRt[WIDTH-1]);
                neg_rem_q  <= signed_op & inRs[WIDTH-1];
                div_zero_q <= is_div_op(inOp) & (inRt == '0);
                operand_q  <= rt_mag;
                orig_rs_q  <= inRs;
                acc_q      <= {{WIDTH{1'b0}}, rs_mag};
            end else if (state == ST_RUN) begin
                cnt   <= cnt + CNT_W'(1);
                acc_q <= acc_next;
            end
            if (finish) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end else if (mt_ok) begin
                if (inWriteHi) hi_q <= inRs;
                if (inWriteLo) lo_q <= inRs;
            end
        end
    end

    assign outHi    = hi_q;
    assign outLo    = lo_q;
    assign outBusy  = (state != ST_IDLE);
    assign outDone  = done_q;
    assign outStall = outBusy & (inStart | inReadHiLo | inWriteHi | inWriteLo);

endmodule
